// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point comparator slice.
// Provides default field widths, the per-operand classification record
// and a helper that builds the canonical quiet NaN for any field widths.
package fp_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MANT_W = 23;
  localparam int DEF_TAG_W  = 4;

  // Magnitude field is sized for formats up to double precision; narrower
  // formats are zero-extended so unsigned comparison stays exact.
  localparam int MAG_MAX_W  = 63;

  typedef struct packed {
    logic                 is_nan;
    logic                 is_zero;
    logic                 sign;
    logic [MAG_MAX_W-1:0] mag;
  } fp_class_t;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  // Returned in 64 bits; callers keep the low 1+exp_w+mant_w bits.
  function automatic logic [63:0] canon_nan(input int exp_w, input int mant_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << mant_w;
    r = r | (64'd1 << (mant_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE-754 operand.
// Ports:
//   x   - operand (sign, exponent, mantissa)
//   cls - classification record: NaN flag, zero flag, sign, magnitude
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W
) (
  input  logic [EXP_W+MANT_W:0] x,
  output fp_class_t             cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  assign exp_f  = x[EXP_W+MANT_W-1 -: EXP_W];
  assign mant_f = x[MANT_W-1:0];

  // Infinity (all-ones exponent, zero mantissa) is deliberately not NaN so
  // it orders like any other value through its magnitude.
  always_comb begin
    cls         = '0;
    cls.sign    = x[EXP_W+MANT_W];
    cls.is_nan  = (&exp_f) && (|mant_f);
    cls.is_zero = (exp_f == '0) && (mant_f == '0);
    cls.mag     = MAG_MAX_W'({exp_f, mant_f});
  end

endmodule

// File: rtl/fpcomp_pipe.sv
// Two-stage pipelined IEEE-754 comparator with min/max and a sideband tag.
// Stage 1 registers operand classification and the magnitude compare;
// stage 2 registers the ordered flags, minNum/maxNum and the tag.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   dataa, datab, in_tag  - operand pair and its tag
//   in_valid, in_ready    - upstream handshake
//   out_valid, out_ready  - downstream handshake
//   lt, eq, gt, unord     - ordering result (exactly one set when valid)
//   leq, geq              - lt|eq and gt|eq, both 0 when unordered
//   min_out, max_out      - minNum / maxNum of the pair
//   out_tag               - tag of the presented result
module fpcomp_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int TAG_W  = DEF_TAG_W,
  localparam int W     = 1 + EXP_W + MANT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     dataa,
  input  logic [W-1:0]     datab,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             unord,
  output logic             leq,
  output logic             geq,
  output logic [W-1:0]     min_out,
  output logic [W-1:0]     max_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [63:0]  QNAN_FULL = canon_nan(EXP_W, MANT_W);
  localparam logic [W-1:0] QNAN      = QNAN_FULL[W-1:0];

  fp_class_t        cls_a, cls_b;
  logic             s1_valid, s2_valid;
  fp_class_t        s1_ca, s1_cb;
  logic             s1_mag_lt, s1_mag_eq;
  logic [W-1:0]     s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_en, s2_en;
  logic             nx_lt, nx_eq, nx_gt, nx_un;
  logic [W-1:0]     nx_min, nx_max;

  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (.x(dataa), .cls(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (.x(datab), .cls(cls_b));

  // A stage may load when its successor is empty or being drained this cycle.
  assign s2_en     = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s1_en     = in_ready;
  assign out_valid = s2_valid;

  // Stage 1: capture classification, raw operands and the full-width
  // unsigned magnitude compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_ca     <= '0;
      s1_cb     <= '0;
      s1_mag_lt <= 1'b0;
      s1_mag_eq <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ca     <= cls_a;
        s1_cb     <= cls_b;
        s1_mag_lt <= cls_a.mag < cls_b.mag;
        s1_mag_eq <= cls_a.mag == cls_b.mag;
        s1_a      <= dataa;
        s1_b      <= datab;
        s1_tag    <= in_tag;
      end
    end
  end

  // Ordering and min/max selection from the stage-1 record.
  // Differing signs are resolved by sign alone, which also orders a zero
  // against a nonzero correctly; two zeros of any sign compare equal, and
  // for that case the negative zero is steered to min_out.
  always_comb begin
    nx_lt  = 1'b0;
    nx_eq  = 1'b0;
    nx_gt  = 1'b0;
    nx_un  = 1'b0;
    nx_min = s1_b;
    nx_max = s1_a;
    if (s1_ca.is_nan || s1_cb.is_nan) begin
      nx_un = 1'b1;
      if (s1_ca.is_nan && s1_cb.is_nan) begin
        nx_min = QNAN;
        nx_max = QNAN;
      end else if (s1_ca.is_nan) begin
        nx_min = s1_b;
        nx_max = s1_b;
      end else begin
        nx_min = s1_a;
        nx_max = s1_a;
      end
    end else begin
      if (s1_ca.is_zero && s1_cb.is_zero) begin
        nx_eq = 1'b1;
      end else if (s1_ca.sign != s1_cb.sign) begin
        nx_lt = s1_ca.sign;
        nx_gt = !s1_ca.sign;
      end else if (s1_mag_eq) begin
        nx_eq = 1'b1;
      end else begin
        nx_lt = s1_mag_lt ^ s1_ca.sign;
        nx_gt = !(s1_mag_lt ^ s1_ca.sign);
      end

      if (s1_ca.is_zero && s1_cb.is_zero) begin
        nx_min = s1_ca.sign ? s1_a : s1_b;
        nx_max = s1_ca.sign ? s1_b : s1_a;
      end else if (nx_lt) begin
        nx_min = s1_a;
        nx_max = s1_b;
      end else begin
        nx_min = s1_b;
        nx_max = s1_a;
      end
    end
  end

  // Stage 2: the output register; holds while stalled by out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      unord    <= 1'b0;
      leq      <= 1'b0;
      geq      <= 1'b0;
      min_out  <= '0;
      max_out  <= '0;
      out_tag  <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        lt      <= nx_lt;
        eq      <= nx_eq;
        gt      <= nx_gt;
        unord   <= nx_un;
        leq     <= nx_lt || nx_eq;
        geq     <= nx_gt || nx_eq;
        min_out <= nx_min;
        max_out <= nx_max;
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fpcomp_pipe.sv
// Self-checking bench for fpcomp_pipe (default 32-bit single precision).
// A queue of expected results is built from a reference model that orders
// floats through a signed integer key; the DUT output is compared against
// the queue head whenever out_valid is high.
module tb_fpcomp_pipe;

  localparam int W     = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [W-1:0]     dataa = '0, datab = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             lt, eq, gt, unord, leq, geq;
  logic [W-1:0]     min_out, max_out;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [5:0]  flags;
    logic [31:0] mn;
    logic [31:0] mx;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t ovr;
  bit   use_ovr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  localparam logic [5:0] F_LT = 6'b100010;
  localparam logic [5:0] F_EQ = 6'b010011;
  localparam logic [5:0] F_GT = 6'b001001;
  localparam logic [5:0] F_UN = 6'b000100;

  always #5 clk = ~clk;

  fpcomp_pipe dut (
    .clk(clk), .reset_n(reset_n),
    .dataa(dataa), .datab(datab), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .lt(lt), .eq(eq), .gt(gt), .unord(unord), .leq(leq), .geq(geq),
    .min_out(min_out), .max_out(max_out), .out_tag(out_tag)
  );

  function automatic bit isNan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Total order on non-NaN floats: signed magnitude mapped onto integers,
  // so both zeros land on 0.
  function automatic longint orderKey(input logic [31:0] x);
    longint m;
    m = longint'({33'd0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] tag);
    exp_t   e;
    longint ka, kb;
    e.a = a; e.b = b; e.tag = tag; e.acc = 0;
    e.flags = F_UN; e.mn = 32'h7FC00000; e.mx = 32'h7FC00000;
    if (isNan(a) && isNan(b)) begin
      e.flags = F_UN;
    end else if (isNan(a)) begin
      e.flags = F_UN; e.mn = b; e.mx = b;
    end else if (isNan(b)) begin
      e.flags = F_UN; e.mn = a; e.mx = a;
    end else begin
      ka = orderKey(a);
      kb = orderKey(b);
      if (ka < kb) begin
        e.flags = F_LT; e.mn = a; e.mx = b;
      end else if (ka > kb) begin
        e.flags = F_GT; e.mn = b; e.mx = a;
      end else begin
        e.flags = F_EQ;
        e.mn = (a == 32'h80000000 || b == 32'h80000000) ? 32'h80000000 : a;
        e.mx = (a == 32'h00000000 || b == 32'h00000000) ? 32'h00000000 : a;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] randOp(input logic [31:0] other);
    logic [31:0] sp [12];
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'h7F800001, 32'hFFC12345, 32'h3F800000,
           32'hBF800000, 32'h00000001, 32'h80000001, 32'h7F7FFFFF};
    case ($urandom_range(0, 5))
      0, 1:    return sp[$urandom_range(0, 11)];
      2:       return {other[31:23], 23'($urandom)};
      3:       return other ^ (32'd1 << $urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cycle);
    end
  endtask

  // Compares handshake and, when a result is presented, every output field
  // against the oldest outstanding expectation. The head becomes visible two
  // cycles after its accept and stays until it is drained.
  task automatic checkOutput();
    bit ev;
    ev = (q.size() > 0) && (cycle >= q[0].acc + 2);
    check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
    check("out_valid", 64'(out_valid), 64'(ev));
    if (out_valid && q.size() > 0) begin
      check("flags", 64'({lt, eq, gt, unord, leq, geq}), 64'(q[0].flags));
      check("min_out", 64'(min_out), 64'(q[0].mn));
      check("max_out", 64'(max_out), 64'(q[0].mx));
      check("out_tag", 64'(out_tag), 64'(q[0].tag));
      check("one_flag", 64'($countones({lt, eq, gt, unord})), 64'd1);
    end
  endtask

  // Drives one cycle of inputs (called at a falling edge), checks, updates
  // the expectation queue and advances to the next falling edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] tag, input bit v, input bit r,
                               output bit accepted);
    exp_t e;
    dataa = a; datab = b; in_tag = tag; in_valid = v; out_ready = r;
    #1;
    checkOutput();
    accepted = in_valid && in_ready;
    if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    if (accepted) begin
      e = use_ovr ? ovr : refModel(a, b, tag);
      e.acc = cycle;
      q.push_back(e);
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic sendDirected(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] tag, input logic [5:0] flags,
                              input logic [31:0] mn, input logic [31:0] mx);
    bit acc;
    acc = 1'b0;
    ovr.a = a; ovr.b = b; ovr.tag = tag; ovr.flags = flags;
    ovr.mn = mn; ovr.mx = mx; ovr.acc = 0;
    use_ovr = 1'b1;
    for (int i = 0; i < 10 && !acc; i++) applyStimulus(a, b, tag, 1'b1, 1'b1, acc);
    use_ovr = 1'b0;
    check("directed_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && q.size() > 0; i++)
      applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, acc);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic checkResetOutputs();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'({lt, eq, gt, unord, leq, geq}), 64'd0);
    check("rst_min", 64'(min_out), 64'd0);
    check("rst_max", 64'(max_out), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
  endtask

  initial begin
    bit          acc;
    logic [31:0] a, b;

    // Power-on reset.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs();
    reset_n = 1'b1;

    // First pair alone so its 2-cycle latency is visible.
    sendDirected(32'h3F800000, 32'h40000000, 4'd3, F_LT, 32'h3F800000, 32'h40000000);
    drain();

    // Directed boundary pairs, streamed.
    sendDirected(32'hC0000000, 32'hBF800000, 4'd5, F_LT, 32'hC0000000, 32'hBF800000);
    sendDirected(32'h80000000, 32'h00000000, 4'd6, F_EQ, 32'h80000000, 32'h00000000);
    sendDirected(32'h00000000, 32'h80000000, 4'd7, F_EQ, 32'h80000000, 32'h00000000);
    sendDirected(32'h7FC00001, 32'h3F800000, 4'd8, F_UN, 32'h3F800000, 32'h3F800000);
    sendDirected(32'h7FC00001, 32'hFF800001, 4'd9, F_UN, 32'h7FC00000, 32'h7FC00000);
    sendDirected(32'h7F800000, 32'h7F7FFFFF, 4'd10, F_GT, 32'h7F7FFFFF, 32'h7F800000);
    sendDirected(32'hFF800000, 32'h80000001, 4'd11, F_LT, 32'hFF800000, 32'h80000001);
    sendDirected(32'h40000000, 32'h3FFFFFFF, 4'd12, F_GT, 32'h3FFFFFFF, 32'h40000000);
    sendDirected(32'hBF800000, 32'h3F800000, 4'd13, F_LT, 32'hBF800000, 32'h3F800000);
    drain();

    // Eight back-to-back pairs with out_ready high.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = randOp(a);
      applyStimulus(a, b, 4'(i), 1'b1, 1'b1, acc);
      check("b2b_accept", 64'(acc), 64'd1);
    end
    drain();

    // Stream with a 5-cycle downstream stall in the middle.
    for (int i = 0; i < 20; i++) begin
      a = randOp($urandom);
      b = randOp(a);
      applyStimulus(a, b, 4'(i), 1'b1, !(i >= 6 && i < 11), acc);
    end
    drain();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      a = randOp($urandom);
      b = randOp(a);
      applyStimulus(a, b, 4'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, acc);
    end
    drain();

    // Reset with two pairs in flight.
    for (int i = 0; i < 2; i++) begin
      a = randOp($urandom);
      b = randOp(a);
      applyStimulus(a, b, 4'(i + 1), 1'b1, 1'b1, acc);
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkResetOutputs();
    q.delete();
    @(posedge clk);
    cycle++;
    @(negedge clk);
    checkResetOutputs();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, acc);

    // Traffic after reset still works.
    for (int i = 0; i < 10; i++) begin
      a = randOp($urandom);
      b = randOp(a);
      applyStimulus(a, b, 4'(i), 1'b1, 1'b1, acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpcomp_pipe.md
FPCOMP_PIPE -- requirements
Module: fpcomp_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_W, default 23, mantissa field width; W = 1+EXP_W+MANT_W (32 by default).
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag passed through with each operand pair.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports dataa, datab  input  W  operands (sign, exponent, mantissa; IEEE-754 layout).
REQ-007 SHALL have port in_tag  input  TAG_W  sideband tag accepted with the operands.
REQ-008 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the downstream handshake.
REQ-010 SHALL have ports lt, eq, gt, unord  output  1 each  a<b, a==b, a>b, unordered (either operand NaN).
REQ-011 SHALL have ports leq, geq  output  1 each  lt|eq and gt|eq; both 0 when unord.
REQ-012 SHALL have ports min_out, max_out  output  W  IEEE minNum and maxNum of the operands.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the operand pair being presented.

Function
REQ-014 SHALL accept an operand pair on a clock edge where in_valid && in_ready.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers classification and magnitude compare; stage 2 registers flags, min/max and tag; latency is exactly 2 cycles with out_ready held high.
REQ-016 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, so each stage advances when its successor is empty or is being drained.
REQ-017 SHALL hold out_valid and all outputs stable while out_valid && !out_ready.
REQ-018 SHALL sustain one result per cycle with out_ready high; no bubbles are inserted.
REQ-019 SHALL classify an operand as NaN when exp is all ones and mant != 0, and as zero when exp == 0 and mant == 0.
REQ-020 SHALL compare magnitudes as the unsigned value {exp,mant} over the full EXP_W+MANT_W bits, not by a partial difference bit.
REQ-021 SHALL treat +0 and -0 as equal (eq=1, leq=1, geq=1).
REQ-022 SHALL, for differing signs with neither operand zero, make the positive operand greater.
REQ-023 SHALL, for equal signs, use the magnitude result directly when the sign is positive and inverted (lt<->gt) when the sign is negative.
REQ-024 SHALL, when either operand is NaN, set unord=1 and lt=eq=gt=leq=geq=0.
REQ-025 SHALL select min_out/max_out from the ordered result; when exactly one operand is NaN, both outputs SHALL be the other operand.
REQ-026 SHALL drive min_out = max_out = canonical quiet NaN (sign 0, exp all ones, mant MSB 1, rest 0) when both operands are NaN.
REQ-027 SHALL set min_out = -0 and max_out = +0 for the pair (+0,-0) in either order.
REQ-028 SHALL treat infinities as ordinary ordered values (+inf > any finite, -inf < any finite).
REQ-029 SHALL assert exactly one of lt/eq/gt/unord whenever out_valid=1.

Reset
REQ-030 SHALL, while reset_n=0, clear s1_valid, s2_valid and out_valid, and drive lt, eq, gt, unord, leq, geq, min_out, max_out and out_tag to 0.
REQ-031 SHALL discard any in-flight operand pairs when reset asserts mid-operation; no result SHALL appear after reset is released.
REQ-032 SHALL drive in_ready=1 on the first cycle after reset is released.

Structure
REQ-033 SHALL take default widths, the canonical-NaN constant and the classification record type (is_nan, is_zero, sign, mag) from the shared package fp_pkg.
REQ-034 SHALL instantiate the combinational sub-module fp_classify, once per operand, to produce the classification record.
REQ-035 SHALL be implementable within 120-400 lines of RTL.

Verification
REQ-036 SHALL cover: a=0x3F800000 (1.0), b=0x40000000 (2.0), tag=3 -> after 2 cycles lt=1, leq=1, min=0x3F800000, max=0x40000000, out_tag=3.
REQ-037 SHALL cover: a=0xC0000000 (-2.0), b=0xBF800000 (-1.0) -> lt=1; then a=0x80000000, b=0x00000000 -> eq=1, min=0x80000000, max=0x00000000.
REQ-038 SHALL cover: a=0x7FC00001 (NaN), b=0x3F800000 -> unord=1, leq=geq=0, min=max=0x3F800000; with both operands NaN -> min=max=0x7FC00000.
REQ-039 SHALL cover: 8 back-to-back pairs with out_ready=1 -> 8 results on 8 consecutive cycles starting 2 cycles after the first accept, in order.
REQ-040 SHALL cover: out_ready=0 for 5 cycles mid-stream -> in_ready drops once both stages are full, outputs held stable, no pair lost or duplicated.
REQ-041 SHALL cover: reset_n pulsed low with 2 pairs in flight -> out_valid=0 and all outputs 0 immediately; no stale result after release.
